// File: rtl/fifo_buffer.sv
// Synchronous first-word-fall-through FIFO with occupancy count and sticky
// overflow/underflow flags; storage is a plain register array, never reset.
module fifo_buffer #(
  parameter int BUS_SIZE   = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [BUS_SIZE-1:0]   w_data,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic [BUS_SIZE-1:0]   r_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [BUS_SIZE-1:0]   mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic isEmpty;
  logic isFull;
  logic wrAccept;
  logic rdAccept;

  // Occupancy never exceeds DEPTH, so the count MSB alone marks full.
  assign isEmpty = (count_q == '0);
  assign isFull  = count_q[ADDR_WIDTH];

  // A write while full still lands when a read frees the head slot that edge.
  assign rdAccept = rd && !isEmpty;
  assign wrAccept = wr && (!isFull || rd);

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wrAccept) begin
      wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
    end
    if (rdAccept) begin
      rdPtr_d = rdPtr_q + ADDR_WIDTH'(1);
    end

    unique case ({wrAccept, rdAccept})
      2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase

    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr && !wrAccept) begin
      overflow_d = 1'b1;
    end
    if (rd && !rdAccept) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset; the reset term only blocks writes while held in reset.
  always_ff @(posedge clk) begin
    if (wrAccept && reset) begin
      mem_q[wrPtr_q] <= w_data;
    end
  end

  assign r_data    = mem_q[rdPtr_q];
  assign empty     = isEmpty;
  assign full      = isFull;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
